// File: rtl/idct8_rows.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | idct8_rows : sequenced 8-point inverse DCT, one output pair per cycle    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module idct8_rows #(
  parameter int DW    = 24,
  parameter int ACC_W = 36
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] y0,
  input  logic [DW-1:0] y1,
  input  logic [DW-1:0] y2,
  input  logic [DW-1:0] y3,
  input  logic [DW-1:0] y4,
  input  logic [DW-1:0] y5,
  input  logic [DW-1:0] y6,
  input  logic [DW-1:0] y7,
  output logic [DW-1:0] x0,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] x2,
  output logic [DW-1:0] x3,
  output logic [DW-1:0] x4,
  output logic [DW-1:0] x5,
  output logic [DW-1:0] x6,
  output logic [DW-1:0] x7,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] c_RND  = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] c_SMAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_SMIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                   r_state, w_state_nxt;
  logic [1:0]               r_cnt;
  logic [DW-1:0]            r_y [8];
  logic [DW-1:0]            r_x [8];
  logic signed [ACC_W-1:0]  r_e, r_o;
  logic signed [8:0]        w_ce [4];
  logic signed [8:0]        w_co [4];
  logic signed [ACC_W-1:0]  w_pe [4];
  logic signed [ACC_W-1:0]  w_po [4];
  logic signed [ACC_W-1:0]  w_esum, w_osum, w_sum, w_dif;
  logic [DW:0]              w_lo, w_hi;
  logic [2:0]               w_pn;
  logic                     w_accept, w_wr;

  // Round half-up, then clamp; MSB of the result flags a clamp.
  function automatic logic [DW:0] rnd_sat(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] r;
    r = (s + c_RND) >>> 8;
    if (r > c_SMAX)      rnd_sat = {1'b1, c_SMAX[DW-1:0]};
    else if (r < c_SMIN) rnd_sat = {1'b1, c_SMIN[DW-1:0]};
    else                 rnd_sat = {1'b0, r[DW-1:0]};
  endfunction

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_wr     = ((r_state == S_RUN) && (r_cnt != 2'd0)) || (r_state == S_FIN);
  // Pair n is written one edge after it was computed; the partner index 7-n is ~n.
  assign w_pn     = (r_state == S_FIN) ? 3'd3 : {1'b0, r_cnt - 2'd1};

  // Cosine sign/magnitude pattern for output pair cnt.
  always_comb begin
    w_ce = '{9'sd91, 9'sd118, 9'sd91, 9'sd49};
    w_co = '{9'sd126, 9'sd106, 9'sd71, 9'sd25};
    case (r_cnt)
      2'd1: begin
        w_ce = '{9'sd91, 9'sd49, -9'sd91, -9'sd118};
        w_co = '{9'sd106, -9'sd25, -9'sd126, -9'sd71};
      end
      2'd2: begin
        w_ce = '{9'sd91, -9'sd49, -9'sd91, 9'sd118};
        w_co = '{9'sd71, -9'sd126, 9'sd25, 9'sd106};
      end
      2'd3: begin
        w_ce = '{9'sd91, -9'sd118, 9'sd91, -9'sd49};
        w_co = '{9'sd25, -9'sd71, 9'sd106, -9'sd126};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_mac
    logic signed [ACC_W-1:0] w_ye, w_yo, w_ke, w_ko;
    assign w_ye    = {{(ACC_W-DW){r_y[2*i][DW-1]}}, r_y[2*i]};
    assign w_yo    = {{(ACC_W-DW){r_y[2*i+1][DW-1]}}, r_y[2*i+1]};
    assign w_ke    = {{(ACC_W-9){w_ce[i][8]}}, w_ce[i]};
    assign w_ko    = {{(ACC_W-9){w_co[i][8]}}, w_co[i]};
    assign w_pe[i] = w_ye * w_ke;
    assign w_po[i] = w_yo * w_ko;
  end

  assign w_esum = w_pe[0] + w_pe[1] + w_pe[2] + w_pe[3];
  assign w_osum = w_po[0] + w_po[1] + w_po[2] + w_po[3];
  assign w_sum  = r_e + r_o;
  assign w_dif  = r_e - r_o;
  assign w_lo   = rnd_sat(w_sum);
  assign w_hi   = rnd_sat(w_dif);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == 2'd3) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 2'd0;
      r_e   <= '0;
      r_o   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_y[i] <= '0;
        r_x[i] <= '0;
      end
    end else begin
      done <= (r_state == S_FIN);
      if (w_accept) begin
        r_y[0] <= y0; r_y[1] <= y1; r_y[2] <= y2; r_y[3] <= y3;
        r_y[4] <= y4; r_y[5] <= y5; r_y[6] <= y6; r_y[7] <= y7;
        busy   <= 1'b1;
        ovf    <= 1'b0;
        r_cnt  <= 2'd0;
      end
      if (r_state == S_RUN) begin
        r_e   <= w_esum;
        r_o   <= w_osum;
        r_cnt <= r_cnt + 2'd1;
      end
      if (w_wr) begin
        r_x[w_pn]  <= w_lo[DW-1:0];
        r_x[~w_pn] <= w_hi[DW-1:0];
        if (w_lo[DW] || w_hi[DW]) ovf <= 1'b1;
      end
      if (r_state == S_FIN) busy <= 1'b0;
    end
  end

  assign x0 = r_x[0];
  assign x1 = r_x[1];
  assign x2 = r_x[2];
  assign x3 = r_x[3];
  assign x4 = r_x[4];
  assign x5 = r_x[5];
  assign x6 = r_x[6];
  assign x7 = r_x[7];

endmodule
`default_nettype wire

// File: tb/tb_idct8_rows.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_idct8_rows : randomized bench for idct8_rows against a cosine model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_idct8_rows;

  localparam int DW    = 24;
  localparam int ACC_W = 36;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] yi [8];
  logic [DW-1:0] xo [8];
  logic          busy, done, ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  idct8_rows #(.DW(DW), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .y0(yi[0]), .y1(yi[1]), .y2(yi[2]), .y3(yi[3]),
    .y4(yi[4]), .y5(yi[5]), .y6(yi[6]), .y7(yi[7]),
    .x0(xo[0]), .x1(xo[1]), .x2(xo[2]), .x3(xo[3]),
    .x4(xo[4]), .x5(xo[5]), .x6(xo[6]), .x7(xo[7]),
    .busy(busy), .done(done), .ovf(ovf)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Basis weight: DC uses g4, otherwise cos((2n+1)k*pi/16) folded onto the Q8 table.
  function automatic longint weight(input int n, input int k);
    int g[9] = '{128, 126, 118, 106, 91, 71, 49, 25, 0};
    int m;
    if (k == 0) return 91;
    m = ((2*n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    if (m > 8) return -g[16-m];
    return g[m];
  endfunction

  function automatic void model(input longint yv[8], output longint ex[8], output bit eovf);
    longint s, r;
    longint mx = (64'sd1 <<< (DW-1)) - 1;
    longint mn = -(64'sd1 <<< (DW-1));
    eovf = 1'b0;
    for (int n = 0; n < 8; n++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += weight(n, k) * yv[k];
      r = (s + 128) >>> 8;
      if (r > mx) begin r = mx; eovf = 1'b1; end
      if (r < mn) begin r = mn; eovf = 1'b1; end
      ex[n] = r;
    end
  endfunction

  function automatic longint rand_y(input bit full);
    longint v;
    if (full) begin
      v = longint'($urandom_range(0, (1 << DW) - 1));
      if (v >= (64'sd1 <<< (DW-1))) v -= (64'sd1 <<< DW);
    end else begin
      v = longint'($urandom_range(0, 4000)) - 2000;
    end
    return v;
  endfunction

  // chain: start is already high in the done cycle of the previous block.
  // hold : keep start high through this block and into its done cycle.
  task automatic run_block(input longint yv[8], input bit chain, input bit hold, input string tag);
    longint ex[8];
    bit     eovf;
    int     lat, bhi;
    if (!chain) @(negedge clk);
    for (int i = 0; i < 8; i++) yi[i] = DW'(yv[i]);
    start = 1'b1;
    @(negedge clk);
    check({tag, "_done_clr"}, longint'(done), 0);
    lat = 1;
    bhi = 0;
    while (!done && lat < 20) begin
      if (busy) bhi++;
      for (int i = 0; i < 8; i++) yi[i] = DW'($urandom);
      start = hold ? 1'b1 : 1'($urandom % 2);
      @(negedge clk);
      lat++;
    end
    if (!hold) start = 1'b0;
    model(yv, ex, eovf);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_busy_cycles"}, bhi, 5);
    check({tag, "_busy_end"}, longint'(busy), 0);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_x%0d", tag, i), longint'($signed(xo[i])), ex[i]);
    check({tag, "_ovf"}, longint'(ovf), longint'(eovf));
  endtask

  task automatic check_cleared(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_x%0d", tag, i), longint'($signed(xo[i])), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_ovf"}, longint'(ovf), 0);
  endtask

  initial begin
    longint dc[8]   = '{256, 0, 0, 0, 0, 0, 0, 0};
    longint ndc[8]  = '{-256, 0, 0, 0, 0, 0, 0, 0};
    longint odd[8]  = '{0, 256, 0, 0, 0, 0, 0, 0};
    longint sat[8]  = '{8388607, 0, 8388607, 0, 8388607, 0, 8388607, 0};
    longint rv[8];
    bit     prev_hold, hold;

    for (int i = 0; i < 8; i++) yi[i] = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    run_block(dc, 1'b0, 1'b0, "dc");
    run_block(ndc, 1'b0, 1'b0, "ndc");
    run_block(odd, 1'b0, 1'b0, "odd");
    run_block(sat, 1'b0, 1'b0, "sat");
    check("sat_x0_max", longint'($signed(xo[0])), 8388607);
    check("sat_ovf_set", longint'(ovf), 1);
    run_block(dc, 1'b0, 1'b0, "dc_after_sat");

    run_block(dc, 1'b0, 1'b1, "hs1");
    run_block(odd, 1'b1, 1'b0, "hs2");

    // Abort a block between edges 2 and 3.
    @(negedge clk);
    for (int i = 0; i < 8; i++) yi[i] = DW'(sat[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_cleared("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_block(dc, 1'b0, 1'b0, "dc_after_rst");

    prev_hold = 1'b0;
    for (int b = 0; b < 24; b++) begin
      for (int i = 0; i < 8; i++) rv[i] = rand_y(b % 3 == 0);
      hold = (b == 23) ? 1'b0 : 1'($urandom % 2);
      run_block(rv, prev_hold, hold, $sformatf("rnd%0d", b));
      prev_hold = hold;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idct8_rows.md
Name: idct8_rows

Overview:
- Sequenced 8-point inverse DCT unit; the decode-side counterpart of the forward DCT even/odd coefficient stages.
- Takes one block of 8 signed DCT coefficients y0..y7 and reconstructs 8 signed samples x0..x7.
- Uses the even/odd butterfly: four even sums from y0/y2/y4/y6 and four odd sums from y1/y3/y5/y7, then x[n] = e[n]+o[n] and x[7-n] = e[n]-o[n].
- Sits after coefficient storage and feeds the pixel-reconstruction path; one block per start handshake.

Parameters:
- DW, 24, width of signed coefficient inputs and sample outputs.
- ACC_W, 36, internal signed accumulator width; must be at least DW+12.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while idle
- y0..y7  in  DW each  signed two's-complement DCT coefficients; captured on accepted start
- x0..x7  out  DW each  signed reconstructed samples
- busy  out  1  high from accepted start until done
- done  out  1  single-cycle pulse when all x are valid
- ovf  out  1  set if any output of the current block saturated; cleared on next accepted start

Behaviour:
- Reset (async, any time, including mid-block): state IDLE, cnt=0; x0..x7=0; busy=0; done=0; ovf=0. Any block in flight is discarded.
- Constants are fixed, Q8, as round(128*cos(k*pi/16)): g1=126, g2=118, g3=106, g4=91, g5=71, g6=49, g7=25. DC weight = g4.
- Even sums:
  - e0 = 91y0 + 118y2 + 91y4 + 49y6
  - e1 = 91y0 + 49y2 - 91y4 - 118y6
  - e2 = 91y0 - 49y2 - 91y4 + 118y6
  - e3 = 91y0 - 118y2 + 91y4 - 49y6
- Odd sums:
  - o0 = 126y1 + 106y3 + 71y5 + 25y7
  - o1 = 106y1 - 25y3 - 126y5 - 71y7
  - o2 = 71y1 - 126y3 + 25y5 + 106y7
  - o3 = 25y1 - 71y3 + 106y5 - 126y7
- Arithmetic:
  - All products and sums are signed, sign-extended to ACC_W.
  - Each output = (sum + 128) arithmetic-shifted right by 8, i.e. round-half-up (floor of sum/256 + 0.5).
  - Result is then saturated to [-2^(DW-1), 2^(DW-1)-1]. Any saturation sets ovf.
- FSM: IDLE, RUN, FIN. Edge k below counts clock edges from the accepted start (edge 0).
  - IDLE: start=1 at edge 0 latches y0..y7 into internal registers, sets busy=1, clears ovf, cnt=0, goes to RUN. start=0 holds IDLE.
  - RUN, edges 1..4: registers e[cnt] and o[cnt], then cnt++. From edge 2 onward, the pair computed on the previous edge is written to x[n] and x[7-n]. After edge 4 (cnt wrapped from 3), go to FIN.
  - FIN, edge 5: writes pair n=3 (x3, x4), pulses done=1 for the cycle following edge 5, sets busy=0, returns to IDLE.
- Latency: done is high in the 6th cycle after the start-sampling edge (5 edges later).
- Output registers that are not being written hold their value. x values from the previous block stay visible until overwritten pair by pair.
- start while busy is ignored, with no queuing. Input y changes after edge 0 have no effect.
- Back-to-back: start may be high in the done cycle; it is accepted at the next edge because state is IDLE then. Maximum throughput is one block per 6 cycles.
- Multipliers: 8 parallel signed DW x 9-bit multiplies per RUN edge; the constant sign pattern is selected by cnt.

Test Plan:
- DC block: y0=256, others 0, start pulse -> x0..x7 all = 91; done exactly 5 edges after the start edge; ovf=0; busy high for 5 cycles.
- Negative DC: y0=-256, others 0 -> x0..x7 all = -91. Checks rounding symmetry on the arithmetic shift.
- Odd basis: y1=256, others 0 -> x0=126, x1=106, x2=71, x3=25, x4=-25, x5=-71, x6=-106, x7=-126; ovf=0.
- Saturation: y0=y2=y4=y6=8388607, others 0 -> x0=8388607 (0x7FFFFF), ovf=1; then a new start with the DC block clears ovf to 0.
- Handshake: start held high continuously with DC block then odd-basis block -> second block accepted on the edge after done; inputs changed mid-block and start pulses while busy have no effect; done spacing = 6 cycles.
- Reset mid-block: assert rst between edges 2 and 3 -> immediately x0..x7=0, busy=0, done=0, ovf=0; after release, a fresh DC block completes normally with all x = 91.
